csi_rx_packet_ctrl: RTL and testbench

- Packet-level sequencer behind the two-lane byte/word aligner.
- Consumes the aligned 32-bit word stream (byte0 = DI, bytes1-2 = WC/short-packet data, byte3 = ECC) and the start-of-transmission pulse from the aligner.
- Validates headers, sequences frame/line/payload phases, counts payload bytes to strip the footer, and emits qualified pixel words with byte enables plus frame/line status and error pulses to the downstream unpacker.

---
 rtl/csi_rx_packet_ctrl_if.sv | 41 ++++
 rtl/csi_rx_packet_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_csi_rx_packet_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/csi_rx_packet_ctrl_if.sv
// Packet controller bus bundle.
//   master : aligner/test side; drives enable, sot, din_valid, din, ecc_ok and observes the
//            results.
//   slave  : packet controller side; consumes the aligned word stream and drives the frame/line
//            pulses, pixel words, counters, error pulses and busy.
interface csi_rx_packet_ctrl_if;
  logic        enable;
  logic        sot;
  logic        din_valid;
  logic [31:0] din;
  logic        ecc_ok;

  logic        fs;
  logic        fe;
  logic        ls;
  logic        le;
  logic        pix_valid;
  logic [31:0] pix_data;
  logic [3:0]  pix_be;
  logic [5:0]  pix_dt;
  logic [15:0] wc;
  logic [15:0] line_num;
  logic [15:0] frame_cnt;
  logic        err_ecc;
  logic        err_wc;
  logic        err_timeout;
  logic        err_abort;
  logic        busy;

  modport master (
    output enable, sot, din_valid, din, ecc_ok,
    input  fs, fe, ls, le, pix_valid, pix_data, pix_be, pix_dt, wc, line_num, frame_cnt,
           err_ecc, err_wc, err_timeout, err_abort, busy
  );

  modport slave (
    input  enable, sot, din_valid, din, ecc_ok,
    output fs, fe, ls, le, pix_valid, pix_data, pix_be, pix_dt, wc, line_num, frame_cnt,
           err_ecc, err_wc, err_timeout, err_abort, busy
  );
endinterface

// File: rtl/csi_rx_packet_ctrl.sv
// CSI-2 receive packet sequencer. Sits behind the lane aligner: validates packet headers,
// walks frame/line/payload phases, counts payload bytes so the footer is stripped, and emits
// qualified pixel words with byte enables plus frame/line status and error pulses.
// Ports:
//   CLK  - clock
//   RST  - synchronous reset, active-high
//   bus  - csi_rx_packet_ctrl_if.slave: enable/sot/din_valid/din/ecc_ok in; fs/fe/ls/le,
//          pix_valid/pix_data/pix_be, pix_dt/wc, line_num/frame_cnt, err_* pulses, busy out.
// All pulses and pix_* are registered one cycle after the qualifying input word.
module csi_rx_packet_ctrl #(
  parameter logic [1:0]  VC_SEL  = 2'd0,
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [15:0] MAX_WC  = 16'd8192
) (
  input logic                  CLK,
  input logic                  RST,
  csi_rx_packet_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StHdr, StPayload, StDrain} state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic [15:0] to_q;
  logic [15:0] rem_q;
  logic [15:0] line_cnt_q;

  logic        fs_q, fe_q, ls_q, le_q;
  logic        pix_valid_q;
  logic [31:0] pix_data_q;
  logic [3:0]  pix_be_q;
  logic [5:0]  pix_dt_q;
  logic [15:0] wc_q;
  logic [15:0] line_num_q;
  logic [15:0] frame_cnt_q;
  logic        err_ecc_q, err_wc_q, err_timeout_q, err_abort_q;

  // Header fields of the current word.
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  assign hdr_vc = bus.din[7:6];
  assign hdr_dt = bus.din[5:0];
  assign hdr_wc = bus.din[23:8];

  // Byte enables for the final payload word, from the bytes still owed (1..4).
  logic [3:0] last_be;
  always_comb begin
    last_be = 4'b1111;
    case (rem_q)
      16'd3:   last_be = 4'b0111;
      16'd2:   last_be = 4'b0011;
      16'd1:   last_be = 4'b0001;
      default: last_be = 4'b1111;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StIdle;
      to_q          <= '0;
      rem_q         <= '0;
      line_cnt_q    <= '0;
      fs_q          <= 1'b0;
      fe_q          <= 1'b0;
      ls_q          <= 1'b0;
      le_q          <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_be_q      <= '0;
      pix_dt_q      <= '0;
      wc_q          <= '0;
      line_num_q    <= '0;
      frame_cnt_q   <= '0;
      err_ecc_q     <= 1'b0;
      err_wc_q      <= 1'b0;
      err_timeout_q <= 1'b0;
      err_abort_q   <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      fs_q          <= 1'b0;
      fe_q          <= 1'b0;
      ls_q          <= 1'b0;
      le_q          <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_be_q      <= '0;
      err_ecc_q     <= 1'b0;
      err_wc_q      <= 1'b0;
      err_timeout_q <= 1'b0;
      err_abort_q   <= 1'b0;

      if (!bus.enable) begin
        // Disabled: park in idle, counters and latched packet info held.
        state_q <= StIdle;
        to_q    <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            to_q <= '0;
            if (bus.sot) state_q <= StHdr;
          end

          StHdr: begin
            if (bus.sot) begin
              // Restart header search; a word alongside SOT belongs to the old packet.
              to_q <= '0;
            end else if (bus.din_valid) begin
              to_q    <= '0;
              state_q <= StDrain;
              if (!bus.ecc_ok) begin
                err_ecc_q <= 1'b1;
              end else if (hdr_vc == VC_SEL) begin
                if (hdr_dt == 6'h00) begin
                  fs_q       <= 1'b1;
                  line_cnt_q <= '0;
                end else if (hdr_dt == 6'h01) begin
                  fe_q        <= 1'b1;
                  line_num_q  <= line_cnt_q;
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                end else if (hdr_dt >= 6'h10) begin
                  if (hdr_wc > MAX_WC) begin
                    err_wc_q <= 1'b1;
                  end else begin
                    ls_q     <= 1'b1;
                    pix_dt_q <= hdr_dt;
                    wc_q     <= hdr_wc;
                    rem_q    <= hdr_wc;
                    if (line_cnt_q != 16'hFFFF) line_cnt_q <= line_cnt_q + 16'd1;
                    // Empty long packet: line ends in the same cycle it starts.
                    if (hdr_wc == 16'd0) le_q <= 1'b1;
                    else                 state_q <= StPayload;
                  end
                end
              end
            end else if (to_q == TimeoutLast) begin
              err_timeout_q <= 1'b1;
              state_q       <= StIdle;
              to_q          <= '0;
            end else begin
              to_q <= to_q + 16'd1;
            end
          end

          StPayload: begin
            if (bus.sot) begin
              // Truncated line: flag it, no LE, line already counted.
              err_abort_q <= 1'b1;
              state_q     <= StHdr;
              to_q        <= '0;
            end else if (bus.din_valid) begin
              to_q        <= '0;
              pix_valid_q <= 1'b1;
              pix_data_q  <= bus.din;
              if (rem_q > 16'd4) begin
                pix_be_q <= 4'b1111;
                rem_q    <= rem_q - 16'd4;
              end else begin
                pix_be_q <= last_be;
                le_q     <= 1'b1;
                rem_q    <= '0;
                state_q  <= StDrain;
              end
            end else if (to_q == TimeoutLast) begin
              err_timeout_q <= 1'b1;
              state_q       <= StIdle;
              to_q          <= '0;
            end else begin
              to_q <= to_q + 16'd1;
            end
          end

          StDrain: begin
            to_q <= '0;
            if (bus.sot) state_q <= StHdr;
          end

          default: begin
            state_q <= StIdle;
            to_q    <= '0;
          end
        endcase
      end
    end
  end

  assign bus.fs          = fs_q;
  assign bus.fe          = fe_q;
  assign bus.ls          = ls_q;
  assign bus.le          = le_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_data    = pix_data_q;
  assign bus.pix_be      = pix_be_q;
  assign bus.pix_dt      = pix_dt_q;
  assign bus.wc          = wc_q;
  assign bus.line_num    = line_num_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.err_ecc     = err_ecc_q;
  assign bus.err_wc      = err_wc_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_abort   = err_abort_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_csi_rx_packet_ctrl.sv
// Directed table-driven bench for csi_rx_packet_ctrl plus hand-written multi-cycle sequences
// (timeout, enable drop, reset mid-payload).
module tb_csi_rx_packet_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  csi_rx_packet_ctrl_if bus ();

  csi_rx_packet_ctrl #(
    .VC_SEL  (2'd0),
    .TIMEOUT (1024),
    .MAX_WC  (16'd8192)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // exp layout: {fs, fe, ls, le, pix_valid, pix_be[3:0], err_ecc, err_wc, err_timeout,
  //              err_abort, busy}
  typedef struct {
    logic        sot;
    logic        dv;
    logic [31:0] din;
    logic        ecc;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_FS   = 4'b1000;
  localparam logic [3:0] P_FE   = 4'b0100;
  localparam logic [3:0] P_LS   = 4'b0010;
  localparam logic [3:0] P_LE   = 4'b0001;
  localparam logic [3:0] E_ECC  = 4'b1000;
  localparam logic [3:0] E_WC   = 4'b0100;
  localparam logic [3:0] E_ABT  = 4'b0001;

  function automatic logic [13:0] ex(logic [3:0] p, logic pv, logic [3:0] be, logic [3:0] err,
                                     logic busy);
    return {p, pv, be, err, busy};
  endfunction

  function automatic void add(logic sot, logic dv, logic [31:0] din, logic ecc,
                              logic [13:0] exp);
    vec_t v;
    v.sot = sot; v.dv = dv; v.din = din; v.ecc = ecc; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // Common vector shapes.
  function automatic void add_sot();
    add(1'b1, 1'b0, 32'h0, 1'b1, ex(P_NONE, 1'b0, 4'h0, 4'h0, 1'b1));
  endfunction

  function automatic void add_quiet(logic [31:0] din);
    add(1'b0, 1'b1, din, 1'b1, ex(P_NONE, 1'b0, 4'h0, 4'h0, 1'b1));
  endfunction

  function automatic logic [13:0] obs();
    return {bus.fs, bus.fe, bus.ls, bus.le, bus.pix_valid, bus.pix_be, bus.err_ecc, bus.err_wc,
            bus.err_timeout, bus.err_abort, bus.busy};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic sot, logic dv, logic [31:0] din, logic ecc);
    bus.sot       = sot;
    bus.din_valid = dv;
    bus.din       = din;
    bus.ecc_ok    = ecc;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_table(string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sot, vecs[i].dv, vecs[i].din, vecs[i].ecc);
      check($sformatf("%s[%0d] outputs", tag, i), 32'(obs()), 32'(vecs[i].exp));
      if (vecs[i].exp[9]) check($sformatf("%s[%0d] pix_data", tag, i), bus.pix_data,
                                vecs[i].din);
    end
    vecs.delete();
  endtask

  initial begin
    int  k;
    bit  seen;

    bus.enable    = 1'b1;
    bus.sot       = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.ecc_ok    = 1'b1;

    // Reset state.
    RST = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("reset outputs", 32'(obs()), 32'h0);
    check("reset frame_cnt", 32'(bus.frame_cnt), 32'h0);
    check("reset line_num", 32'(bus.line_num), 32'h0);
    RST = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Frame: FS, three RAW8 lines of 8 bytes, FE.
    add_sot();
    add(1'b0, 1'b1, 32'hAB00_0000, 1'b1, ex(P_FS, 1'b0, 4'h0, 4'h0, 1'b1));
    for (int l = 0; l < 3; l++) begin
      add_sot();
      add(1'b0, 1'b1, 32'h0000_082A, 1'b1, ex(P_LS, 1'b0, 4'h0, 4'h0, 1'b1));
      add(1'b0, 1'b1, 32'hD000_0000 + 32'(l * 2), 1'b1, ex(P_NONE, 1'b1, 4'hF, 4'h0, 1'b1));
      add(1'b0, 1'b1, 32'hD000_0001 + 32'(l * 2), 1'b1, ex(P_LE, 1'b1, 4'hF, 4'h0, 1'b1));
      add_quiet(32'hFFFF_FFFF);
    end
    add_sot();
    add(1'b0, 1'b1, 32'h0000_0001, 1'b1, ex(P_FE, 1'b0, 4'h0, 4'h0, 1'b1));
    run_table("frame");
    check("frame line_num", 32'(bus.line_num), 32'd3);
    check("frame frame_cnt", 32'(bus.frame_cnt), 32'd1);
    check("frame pix_dt", 32'(bus.pix_dt), 32'h2A);
    check("frame wc", 32'(bus.wc), 32'd8);

    // WC=10: BE 1111, 1111, 0011; footer silent.
    add_sot();
    add(1'b0, 1'b1, 32'h0000_0A2A, 1'b1, ex(P_LS, 1'b0, 4'h0, 4'h0, 1'b1));
    add(1'b0, 1'b1, 32'h1111_1111, 1'b1, ex(P_NONE, 1'b1, 4'hF, 4'h0, 1'b1));
    add(1'b0, 1'b1, 32'h2222_2222, 1'b1, ex(P_NONE, 1'b1, 4'hF, 4'h0, 1'b1));
    add(1'b0, 1'b1, 32'h3333_3333, 1'b1, ex(P_LE, 1'b1, 4'h3, 4'h0, 1'b1));
    add_quiet(32'h4444_4444);
    // Bad ECC: error pulse, payload ignored.
    add_sot();
    add(1'b0, 1'b1, 32'h0000_082A, 1'b0, ex(P_NONE, 1'b0, 4'h0, E_ECC, 1'b1));
    add_quiet(32'h5555_5555);
    add_quiet(32'h6666_6666);
    // Oversized WC.
    add_sot();
    add(1'b0, 1'b1, 32'h0040_002A, 1'b1, ex(P_NONE, 1'b0, 4'h0, E_WC, 1'b1));
    add_quiet(32'h7777_7777);
    // Foreign VC: silently drained, stays busy.
    add_sot();
    add_quiet(32'h0000_086A);
    add_quiet(32'h8888_8888);
    add(1'b0, 1'b0, 32'h0, 1'b1, ex(P_NONE, 1'b0, 4'h0, 4'h0, 1'b1));
    // Abort after 1 of 4 words, then a normal 4-byte line.
    add_sot();
    add(1'b0, 1'b1, 32'h0000_102A, 1'b1, ex(P_LS, 1'b0, 4'h0, 4'h0, 1'b1));
    add(1'b0, 1'b1, 32'h9999_9999, 1'b1, ex(P_NONE, 1'b1, 4'hF, 4'h0, 1'b1));
    add(1'b1, 1'b0, 32'h0, 1'b1, ex(P_NONE, 1'b0, 4'h0, E_ABT, 1'b1));
    add(1'b0, 1'b1, 32'h0000_042A, 1'b1, ex(P_LS, 1'b0, 4'h0, 4'h0, 1'b1));
    add(1'b0, 1'b1, 32'hAAAA_AAAA, 1'b1, ex(P_LE, 1'b1, 4'hF, 4'h0, 1'b1));
    add_quiet(32'hBBBB_BBBB);
    // WC=0: LS and LE together.
    add_sot();
    add(1'b0, 1'b1, 32'h0000_002A, 1'b1, ex(P_LS | P_LE, 1'b0, 4'h0, 4'h0, 1'b1));
    // FE latches 7 lines (3 + WC10 + aborted + WC4 + WC0).
    add_sot();
    add(1'b0, 1'b1, 32'h0000_0001, 1'b1, ex(P_FE, 1'b0, 4'h0, 4'h0, 1'b1));
    // Word coincident with SOT is not a header; the following word is.
    add(1'b1, 1'b1, 32'h0000_0001, 1'b1, ex(P_NONE, 1'b0, 4'h0, 4'h0, 1'b1));
    add(1'b0, 1'b1, 32'h0000_0000, 1'b1, ex(P_FS, 1'b0, 4'h0, 4'h0, 1'b1));
    run_table("pkts");
    check("pkts line_num", 32'(bus.line_num), 32'd7);
    check("pkts frame_cnt", 32'(bus.frame_cnt), 32'd2);

    // Timeout: stall in PAYLOAD after one word.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_082A, 1'b1);
    drive(1'b0, 1'b1, 32'hCCCC_CCCC, 1'b1);
    k = 0;
    seen = 1'b0;
    for (int i = 1; i <= 1100 && !seen; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (bus.err_timeout === 1'b1) begin
        seen = 1'b1;
        k = i;
      end
    end
    check("timeout stall cycles", 32'(k), 32'd1024);
    check("timeout busy", 32'(bus.busy), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("timeout pulse width", 32'(bus.err_timeout), 32'd0);

    // Enable drop mid-payload: idle, no pulses, counters held.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_082A, 1'b1);
    bus.enable = 1'b0;
    drive(1'b0, 1'b1, 32'hDDDD_DDDD, 1'b1);
    check("disable outputs", 32'(obs()), 32'h0);
    check("disable frame_cnt", 32'(bus.frame_cnt), 32'd2);
    bus.enable = 1'b1;

    // Reset mid-payload: everything cleared.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_082A, 1'b1);
    drive(1'b0, 1'b1, 32'hEEEE_EEEE, 1'b1);
    RST = 1'b1;
    drive(1'b0, 1'b1, 32'hEEEE_EEEF, 1'b1);
    check("rst outputs", 32'(obs()), 32'h0);
    check("rst frame_cnt", 32'(bus.frame_cnt), 32'd0);
    check("rst line_num", 32'(bus.line_num), 32'd0);
    check("rst pix_data", bus.pix_data, 32'h0);
    check("rst wc", 32'(bus.wc), 32'd0);
    RST = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
